riscv_multicycle_controller: RTL and testbench
==============================================

RISCV_MULTICYCLE_CONTROLLER -- requirements
Module: riscv_multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; every encoding below is fixed.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  7  instruction[6:0] from the held instruction register.
REQ-005 func3  input  3  instruction[14:12].
REQ-006 func7  input  7  instruction[31:25]; only bit 5 is used.
REQ-007 zero  input  1  ALU zero flag, valid in the same cycle as ALUControl.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  PC update, memory address select (0=PC, 1=ALUOut), memory write, instruction-register load, register-file write.
REQ-009 ResultSrc  output  2  00=ALUOut register, 01=memory data register, 10=ALU result, 11=immediate.
REQ-010 ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 data; ALUSrcB  output  2  00=rs2 data, 01=immediate, 10=constant 4.
REQ-011 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu.
REQ-012 ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded combinationally from opcode in every state.
REQ-013 instr_done  output  1  one-cycle pulse in the final state of each legal instruction.
REQ-014 illegal_instr  output  1  one-cycle pulse in DECODE when the opcode/func3 is unsupported.

Function
REQ-015 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, JALR, JALRWB, LUI, BRANCH; all unlisted outputs SHALL be 0 in each state.
REQ-016 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1; next state DECODE.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut); next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR, 0110111 -> LUI, otherwise -> FETCH with illegal_instr=1.
REQ-018 Legal func3: R/I types {000,010,011,100,110,111}; branch {000 beq, 001 bne, 100 blt, 101 bge}; load/store 010 only; jalr 000 only; anything else SHALL be treated as illegal in DECODE.
REQ-019 MEMADR: ALUSrcA=10, ALUSrcB=01, add; load -> MEMREAD, store -> MEMWRITE.
REQ-020 MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB; MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
REQ-021 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, instr_done=1 -> FETCH.
REQ-022 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01; both -> ALUWB.
REQ-023 ALU decode in EXECR/EXECI: func3 000 -> add, or sub only when R-type and func7[5]=1; 010 slt; 011 sltu; 100 xor; 110 or; 111 and.
REQ-024 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (rd <= OldPC+4).
REQ-026 JALR: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1 -> JALRWB; JALRWB: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1, instr_done=1 -> FETCH.
REQ-027 LUI: ResultSrc=11, RegWrite=1, instr_done=1 -> FETCH.
REQ-028 BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00; beq/bne use sub, blt/bge use slt; PCWrite SHALL equal taken, where taken = zero (beq, bge) or !zero (bne, blt); instr_done=1 -> FETCH.
REQ-029 Latency in cycles, FETCH to last state inclusive: load 5, store 4, R/I 4, jal 4, jalr 4, branch 3, lui 3, illegal 2.
REQ-030 Write enables (PCWrite, IRWrite, MemWrite, RegWrite) SHALL never be asserted in the same cycle as illegal_instr.

Reset
REQ-031 When rst=1 at a rising edge, the state SHALL become FETCH regardless of the current state, including mid-instruction.
REQ-032 While rst=1, all 1-bit outputs SHALL be forced to 0 and multi-bit outputs to 0; FETCH behaviour starts in the first cycle with rst=0.

Verification
REQ-033 Reset held 2 cycles during MEMREAD -> all outputs 0 during reset; first cycle after release shows IRWrite=1, PCWrite=1.
REQ-034 lw (opcode 0000011, func3 010) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5.
REQ-035 add then sub (0110011, func3 000, func7 0000000 / 0100000) -> ALUControl 000 / 001 in EXECR; RegWrite in ALUWB; 4 cycles each.
REQ-036 beq with zero=1 and bne with zero=1 -> PCWrite=1 in BRANCH for beq, 0 for bne; bge with zero=0 -> ALUControl=101, PCWrite=0.
REQ-037 jal then jalr -> PCWrite=1 in JAL and JALR; RegWrite=1 in ALUWB and JALRWB; ImmSrc 011 and 000.
REQ-038 opcode 1111111, and R-type func3 001 -> illegal_instr=1 in DECODE, no write enables, FETCH on the next cycle.

Source files
------------

// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32I control unit: a Moore FSM that sequences fetch, decode and
// execute of a held instruction and drives the datapath selects and enables.
module riscv_multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal_instr
);

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALU operations
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_JAL, S_JALR, S_JALRWB, S_LUI, S_BRANCH
  } state_t;

  state_t     state_reg;
  state_t     state_next;

  state_t     decode_target;
  logic       decode_legal;
  logic       alu_f3_legal;
  logic       br_f3_legal;
  logic [2:0] exec_alu;
  logic [2:0] imm_src_dec;
  logic       branch_taken;

  logic       pc_write_raw;
  logic       adr_src_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic [1:0] result_src_raw;
  logic [1:0] alu_src_a_raw;
  logic [1:0] alu_src_b_raw;
  logic [2:0] alu_control_raw;
  logic       instr_done_raw;
  logic       illegal_raw;

  // Only func7[5] selects sub vs add; the remaining bits are deliberately ignored.
  logic func7_unused;
  assign func7_unused = ^{func7[6], func7[4:0]};

  // State register; reset returns to FETCH from any state, mid-instruction included.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  // Supported func3 sets for ALU-type and branch instructions.
  always_comb begin
    alu_f3_legal = 1'b0;
    br_f3_legal  = 1'b0;
    case (func3)
      3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111: alu_f3_legal = 1'b1;
      default: alu_f3_legal = 1'b0;
    endcase
    case (func3)
      3'b000, 3'b001, 3'b100, 3'b101: br_f3_legal = 1'b1;
      default: br_f3_legal = 1'b0;
    endcase
  end

  // Opcode dispatch out of DECODE together with the legality verdict.
  always_comb begin
    decode_target = S_FETCH;
    decode_legal  = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: begin
        decode_target = S_MEMADR;
        decode_legal  = (func3 == 3'b010);
      end
      OP_R: begin
        decode_target = S_EXECR;
        decode_legal  = alu_f3_legal;
      end
      OP_I: begin
        decode_target = S_EXECI;
        decode_legal  = alu_f3_legal;
      end
      OP_BRANCH: begin
        decode_target = S_BRANCH;
        decode_legal  = br_f3_legal;
      end
      OP_JAL: begin
        decode_target = S_JAL;
        decode_legal  = 1'b1;
      end
      OP_JALR: begin
        decode_target = S_JALR;
        decode_legal  = (func3 == 3'b000);
      end
      OP_LUI: begin
        decode_target = S_LUI;
        decode_legal  = 1'b1;
      end
      default: begin
        decode_target = S_FETCH;
        decode_legal  = 1'b0;
      end
    endcase
  end

  // ALU operation for register/immediate arithmetic; sub exists only for R-type.
  always_comb begin
    exec_alu = ALU_ADD;
    case (func3)
      3'b000:  exec_alu = ((opcode == OP_R) && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  exec_alu = ALU_SLT;
      3'b011:  exec_alu = ALU_SLTU;
      3'b100:  exec_alu = ALU_XOR;
      3'b110:  exec_alu = ALU_OR;
      3'b111:  exec_alu = ALU_AND;
      default: exec_alu = ALU_ADD;
    endcase
  end

  // Branch resolution from the ALU zero flag (sub for eq/ne, slt for lt/ge).
  always_comb begin
    branch_taken = 1'b0;
    case (func3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = !zero;
      3'b101:  branch_taken = zero;
      default: branch_taken = 1'b0;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src_dec = IMM_I;
    case (opcode)
      OP_STORE:  imm_src_dec = IMM_S;
      OP_BRANCH: imm_src_dec = IMM_B;
      OP_JAL:    imm_src_dec = IMM_J;
      OP_LUI:    imm_src_dec = IMM_U;
      default:   imm_src_dec = IMM_I;
    endcase
  end

  // Next-state and per-state Moore outputs; everything defaults to 0.
  always_comb begin
    state_next      = state_reg;
    pc_write_raw    = 1'b0;
    adr_src_raw     = 1'b0;
    mem_write_raw   = 1'b0;
    ir_write_raw    = 1'b0;
    reg_write_raw   = 1'b0;
    result_src_raw  = 2'b00;
    alu_src_a_raw   = 2'b00;
    alu_src_b_raw   = 2'b00;
    alu_control_raw = ALU_ADD;
    instr_done_raw  = 1'b0;
    illegal_raw     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_write_raw   = 1'b1;
        alu_src_a_raw  = 2'b00;
        alu_src_b_raw  = 2'b10;
        result_src_raw = 2'b10;
        pc_write_raw   = 1'b1;
        state_next     = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut for a later branch/jal target.
        alu_src_a_raw = 2'b01;
        alu_src_b_raw = 2'b01;
        illegal_raw   = !decode_legal;
        state_next    = decode_legal ? decode_target : S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a_raw = 2'b10;
        alu_src_b_raw = 2'b01;
        state_next    = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_raw = 1'b1;
        state_next  = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_raw = 2'b01;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_raw    = 1'b1;
        mem_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_raw   = 2'b10;
        alu_src_b_raw   = 2'b00;
        alu_control_raw = exec_alu;
        state_next      = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_raw   = 2'b10;
        alu_src_b_raw   = 2'b01;
        alu_control_raw = exec_alu;
        state_next      = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = S_FETCH;
      end
      S_JAL: begin
        // PC <= ALUOut (target from DECODE) while ALU forms OldPC+4 for rd.
        alu_src_a_raw = 2'b01;
        alu_src_b_raw = 2'b10;
        pc_write_raw  = 1'b1;
        state_next    = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a_raw  = 2'b10;
        alu_src_b_raw  = 2'b01;
        result_src_raw = 2'b10;
        pc_write_raw   = 1'b1;
        state_next     = S_JALRWB;
      end
      S_JALRWB: begin
        alu_src_a_raw  = 2'b01;
        alu_src_b_raw  = 2'b10;
        result_src_raw = 2'b10;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = S_FETCH;
      end
      S_LUI: begin
        result_src_raw = 2'b11;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_raw   = 2'b10;
        alu_src_b_raw   = 2'b00;
        alu_control_raw = func3[2] ? ALU_SLT : ALU_SUB;
        pc_write_raw    = branch_taken;
        instr_done_raw  = 1'b1;
        state_next      = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Outputs are held at zero while reset is asserted.
  always_comb begin
    PCWrite       = pc_write_raw;
    AdrSrc        = adr_src_raw;
    MemWrite      = mem_write_raw;
    IRWrite       = ir_write_raw;
    RegWrite      = reg_write_raw;
    ResultSrc     = result_src_raw;
    ALUSrcA       = alu_src_a_raw;
    ALUSrcB       = alu_src_b_raw;
    ALUControl    = alu_control_raw;
    ImmSrc        = imm_src_dec;
    instr_done    = instr_done_raw;
    illegal_instr = illegal_raw;
    if (rst) begin
      PCWrite       = 1'b0;
      AdrSrc        = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUControl    = 3'b000;
      ImmSrc        = 3'b000;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed, table-driven bench for the multicycle controller: one row per
// clock cycle with hand-computed outputs, plus reset and latency sequences.
module tb_riscv_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic       instr_done, illegal_instr;
  logic [18:0] act;

  always #5 clk = ~clk;

  riscv_multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .instr_done(instr_done), .illegal_instr(illegal_instr)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
  //  ALUControl, ImmSrc, instr_done, illegal_instr}
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal_instr};

  typedef struct {
    string       name;
    logic        r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, BAD = 7'b1111111;

  function automatic logic [18:0] mk(logic [4:0] en, logic [1:0] rs,
                                     logic [1:0] sa, logic [1:0] sb,
                                     logic [2:0] alu, logic [2:0] imm,
                                     logic [1:0] fl);
    return {en, rs, sa, sb, alu, imm, fl};
  endfunction

  task automatic push(string n, logic r, logic [6:0] op, logic [2:0] f3,
                      logic [6:0] f7, logic z, logic [18:0] e);
    vec_t v;
    v.name = n; v.r = r; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic push_f(string n, logic [6:0] op, logic [2:0] f3,
                        logic [6:0] f7, logic z, logic [2:0] imm);
    push({n, ".fetch"}, 1'b0, op, f3, f7, z,
         mk(5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, imm, 2'b00));
  endtask

  task automatic push_fd(string n, logic [6:0] op, logic [2:0] f3,
                         logic [6:0] f7, logic z, logic [2:0] imm);
    push_f(n, op, f3, f7, z, imm);
    push({n, ".decode"}, 1'b0, op, f3, f7, z,
         mk(5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, imm, 2'b00));
  endtask

  task automatic push_illegal(string n, logic [6:0] op, logic [2:0] f3,
                              logic [2:0] imm);
    push_f(n, op, f3, 7'd0, 1'b0, imm);
    push({n, ".decode_ill"}, 1'b0, op, f3, 7'd0, 1'b0,
         mk(5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, imm, 2'b01));
  endtask

  task automatic check(string n, logic [18:0] got, logic [18:0] want);
    checks++;
    if (got !== want)
      $display("FAIL %s: got %b required %b", n, got, want);
    else begin
      passes++;
      $display("ok   %s: out %b", n, got);
    end
  endtask

  task automatic check_int(string n, int got, int want);
    checks++;
    if (got != want)
      $display("FAIL %s: got %0d cycles required %0d", n, got, want);
    else begin
      passes++;
      $display("ok   %s: %0d cycles", n, got);
    end
  endtask

  // Drive one row at a falling edge, compare mid-cycle, advance one clock.
  task automatic apply(vec_t v);
    rst = v.r; opcode = v.op; func3 = v.f3; func7 = v.f7; zero = v.z;
    #1;
    check(v.name, act, v.exp);
    @(negedge clk);
  endtask

  // Cycles from FETCH up to and including the instr_done/illegal cycle.
  task automatic run_lat(string n, logic [6:0] op, logic [2:0] f3, int want);
    int cyc;
    bit seen;
    rst = 1'b1; opcode = op; func3 = f3; func7 = 7'd0; zero = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      #1;
      cyc++;
      if (instr_done || illegal_instr) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) cyc = -1;
    check_int({n, ".latency"}, cyc, want);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; opcode = RT; func3 = 3'b000; func7 = 7'd0; zero = 1'b0;

    // ---------------- vector table ----------------
    push("reset", 1'b1, ST, 3'b010, 7'd0, 1'b0, 19'd0);

    push_fd("lw", LD, 3'b010, 7'd0, 1'b0, 3'b000);
    push("lw.memadr",  1'b0, LD, 3'b010, 7'd0, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00));
    push("lw.memread", 1'b0, LD, 3'b010, 7'd0, 1'b0, mk(5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00));
    push("lw.memwb",   1'b0, LD, 3'b010, 7'd0, 1'b0, mk(5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10));

    push_fd("sw", ST, 3'b010, 7'd0, 1'b0, 3'b001);
    push("sw.memadr",   1'b0, ST, 3'b010, 7'd0, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 2'b00));
    push("sw.memwrite", 1'b0, ST, 3'b010, 7'd0, 1'b0, mk(5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 2'b10));

    push_fd("add", RT, 3'b000, 7'b0000000, 1'b0, 3'b000);
    push("add.execr", 1'b0, RT, 3'b000, 7'b0000000, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 2'b00));
    push("add.aluwb", 1'b0, RT, 3'b000, 7'b0000000, 1'b0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10));

    push_fd("sub", RT, 3'b000, 7'b0100000, 1'b0, 3'b000);
    push("sub.execr", 1'b0, RT, 3'b000, 7'b0100000, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 2'b00));
    push("sub.aluwb", 1'b0, RT, 3'b000, 7'b0100000, 1'b0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10));

    push_fd("addi_f7", IT, 3'b000, 7'b0100000, 1'b0, 3'b000);
    push("addi_f7.execi", 1'b0, IT, 3'b000, 7'b0100000, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00));
    push("addi_f7.aluwb", 1'b0, IT, 3'b000, 7'b0100000, 1'b0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10));

    push_fd("sltu", RT, 3'b011, 7'd0, 1'b0, 3'b000);
    push("sltu.execr", 1'b0, RT, 3'b011, 7'd0, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 3'b110, 3'b000, 2'b00));
    push("sltu.aluwb", 1'b0, RT, 3'b011, 7'd0, 1'b0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10));

    push_fd("xor", RT, 3'b100, 7'd0, 1'b0, 3'b000);
    push("xor.execr", 1'b0, RT, 3'b100, 7'd0, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 3'b100, 3'b000, 2'b00));
    push("xor.aluwb", 1'b0, RT, 3'b100, 7'd0, 1'b0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10));

    push_fd("ori", IT, 3'b110, 7'd0, 1'b0, 3'b000);
    push("ori.execi", 1'b0, IT, 3'b110, 7'd0, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 3'b011, 3'b000, 2'b00));
    push("ori.aluwb", 1'b0, IT, 3'b110, 7'd0, 1'b0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10));

    push_fd("slti", IT, 3'b010, 7'd0, 1'b0, 3'b000);
    push("slti.execi", 1'b0, IT, 3'b010, 7'd0, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 3'b101, 3'b000, 2'b00));
    push("slti.aluwb", 1'b0, IT, 3'b010, 7'd0, 1'b0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10));

    push_fd("andi", IT, 3'b111, 7'd0, 1'b0, 3'b000);
    push("andi.execi", 1'b0, IT, 3'b111, 7'd0, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 2'b00));
    push("andi.aluwb", 1'b0, IT, 3'b111, 7'd0, 1'b0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10));

    push_fd("beq_z1", BR, 3'b000, 7'd0, 1'b1, 3'b010);
    push("beq_z1.branch", 1'b0, BR, 3'b000, 7'd0, 1'b1, mk(5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 2'b10));
    push_fd("bne_z1", BR, 3'b001, 7'd0, 1'b1, 3'b010);
    push("bne_z1.branch", 1'b0, BR, 3'b001, 7'd0, 1'b1, mk(5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 2'b10));
    push_fd("bge_z0", BR, 3'b101, 7'd0, 1'b0, 3'b010);
    push("bge_z0.branch", 1'b0, BR, 3'b101, 7'd0, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 3'b101, 3'b010, 2'b10));
    push_fd("blt_z0", BR, 3'b100, 7'd0, 1'b0, 3'b010);
    push("blt_z0.branch", 1'b0, BR, 3'b100, 7'd0, 1'b0, mk(5'b10000, 2'b00, 2'b10, 2'b00, 3'b101, 3'b010, 2'b10));

    push_fd("jal", JL, 3'b101, 7'd0, 1'b0, 3'b011);
    push("jal.jal",   1'b0, JL, 3'b101, 7'd0, 1'b0, mk(5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 2'b00));
    push("jal.aluwb", 1'b0, JL, 3'b101, 7'd0, 1'b0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 2'b10));

    push_fd("jalr", JR, 3'b000, 7'd0, 1'b0, 3'b000);
    push("jalr.jalr",   1'b0, JR, 3'b000, 7'd0, 1'b0, mk(5'b10000, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00));
    push("jalr.jalrwb", 1'b0, JR, 3'b000, 7'd0, 1'b0, mk(5'b00001, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 2'b10));

    push_fd("lui", LU, 3'b000, 7'd0, 1'b0, 3'b100);
    push("lui.lui", 1'b0, LU, 3'b000, 7'd0, 1'b0, mk(5'b00001, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 2'b10));

    push_illegal("ill_op",     BAD, 3'b000, 3'b000);
    push_illegal("ill_r_sll",  RT,  3'b001, 3'b000);
    push_illegal("ill_i_srl",  IT,  3'b101, 3'b000);
    push_illegal("ill_lb",     LD,  3'b000, 3'b000);
    push_illegal("ill_sh",     ST,  3'b001, 3'b001);
    push_illegal("ill_br010",  BR,  3'b010, 3'b010);
    push_illegal("ill_jalr01", JR,  3'b001, 3'b000);
    push_f("after_ill", LU, 3'b000, 7'd0, 1'b0, 3'b100);

    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // ---------------- reset in the middle of a load ----------------
    vecs.delete();
    push("rstmid.hold", 1'b1, LD, 3'b010, 7'd0, 1'b0, 19'd0);
    push_fd("rstmid.lw", LD, 3'b010, 7'd0, 1'b0, 3'b000);
    push("rstmid.memadr",  1'b0, LD, 3'b010, 7'd0, 1'b0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00));
    push("rstmid.memread", 1'b0, LD, 3'b010, 7'd0, 1'b0, mk(5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00));
    push("rstmid.rst1",    1'b1, ST, 3'b010, 7'd0, 1'b1, 19'd0);
    push("rstmid.rst2",    1'b1, ST, 3'b010, 7'd0, 1'b1, 19'd0);
    push_fd("rstmid.after", LD, 3'b010, 7'd0, 1'b0, 3'b000);
    foreach (vecs[i]) apply(vecs[i]);

    // ---------------- latency from FETCH to last state ----------------
    run_lat("lw",      LD,  3'b010, 5);
    run_lat("sw",      ST,  3'b010, 4);
    run_lat("add",     RT,  3'b000, 4);
    run_lat("addi",    IT,  3'b000, 4);
    run_lat("jal",     JL,  3'b000, 4);
    run_lat("jalr",    JR,  3'b000, 4);
    run_lat("beq",     BR,  3'b000, 3);
    run_lat("lui",     LU,  3'b000, 3);
    run_lat("illegal", BAD, 3'b000, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
